// File: rtl/rr_mux_pkg.sv
// Shared defaults and select-width helper for the round-robin output mux.
package rr_mux_pkg;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_NCH       = 4;
  localparam int DEF_MAX_BURST = 4;

  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: scans req starting one past last_grant, wrapping at NCH-1.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int NCH = DEF_NCH,
  localparam int SW  = sel_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  last_grant,
  output logic [NCH-1:0] grant,
  output logic [SW-1:0]  grant_idx
);

  logic [SW-1:0] idx;
  logic          found;

  // Visits every channel once; last_grant itself is the final candidate.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = last_grant;
    for (int i = 0; i < NCH; i++) begin
      idx = (idx == SW'(NCH - 1)) ? '0 : idx + SW'(1);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/rr_mux.sv
// Round-robin N:1 mux with a single registered output stage.
// Define RR_MUX_HOLD_EN to let a granted channel keep the grant for up to MAX_BURST beats.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NCH       = DEF_NCH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         in_valid,
  input  logic [NCH*WIDTH-1:0]   in_data,
  output logic [NCH-1:0]         in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [sel_w(NCH)-1:0]  out_sel,
  input  logic                   out_ready
);

  localparam int SW = sel_w(NCH);

  if (NCH < 2 || NCH > 16 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_param
    $error("rr_mux: parameter out of range");
  end

  logic                 load_en;
  logic [SW-1:0]        last_grant;
  logic [NCH-1:0]       req_arb;
  logic [NCH-1:0]       grant;
  logic [SW-1:0]        grant_idx;
  logic [WIDTH-1:0]     ch_data [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  assign load_en = !out_valid || out_ready;

`ifdef RR_MUX_HOLD_EN
  logic [3:0] burst_left;
  logic       hold;
  logic       xfer;

  // While holding, only the owner is offered to the arbiter, so it wins after a full scan.
  assign hold    = (burst_left != 4'd0) && in_valid[last_grant];
  assign req_arb = hold ? (NCH'(1) << last_grant) : in_valid;
  assign xfer    = |in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_left <= 4'd0;
    end else if (xfer) begin
      burst_left <= hold ? burst_left - 4'd1 : 4'(MAX_BURST - 1);
    end
  end
`else
  assign req_arb = in_valid;
`endif

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req        (req_arb),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign in_ready = (reset || !load_en) ? '0 : grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      last_grant <= SW'(NCH - 1);
    end else if (load_en) begin
      out_valid <= |in_valid;
      if (|in_valid) begin
        out_data   <= ch_data[grant_idx];
        out_sel    <= grant_idx;
        last_grant <= grant_idx;
      end
    end
  end

endmodule

// File: doc/rr_mux.md
RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data bits per channel.
REQ-002 SHALL have parameter NCH, default 4, number of input channels (2..16).
REQ-003 SHALL have parameter MAX_BURST, default 4, beats per grant when RR_MUX_HOLD_EN is defined (1..15).
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  NCH  per-channel request; bit i belongs to channel i.
REQ-007 in_data  input  NCH*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-008 in_ready  output  NCH  one-hot or zero; bit i high when channel i's beat is taken this cycle.
REQ-009 out_valid  output  1  out_data/out_sel hold a valid beat.
REQ-010 out_data  output  WIDTH  registered selected data.
REQ-011 out_sel  output  max(1,clog2(NCH))  index of channel that produced out_data.
REQ-012 out_ready  input  1  downstream accepts beat when out_valid && out_ready.

Function
REQ-013 Output stage SHALL be a single register; load enable = !out_valid || out_ready.
REQ-014 When load enable is high and any in_valid bit set, SHALL grant exactly one channel, assert its in_ready combinationally, and load its data/index into out_data/out_sel on the next edge with out_valid=1 (latency 1 cycle).
REQ-015 When load enable is high and no in_valid set, SHALL clear out_valid next edge; out_data/out_sel hold previous value.
REQ-016 When load enable is low, in_ready SHALL be all zeros and output register SHALL hold.
REQ-017 Grant SHALL be round-robin: search starts at channel (last_grant+1) mod NCH, wraps past NCH-1 to 0; first valid channel wins.
REQ-018 last_grant SHALL update only on an actual transfer (in_ready bit high).
REQ-019 A single requesting channel SHALL be granted every eligible cycle (no bubbles; full throughput with out_ready held high).
REQ-020 in_ready SHALL never depend on in_data; in_valid may be withdrawn without a transfer (no lock on un-granted channel).
REQ-021 Simultaneous output pop and new load in one cycle SHALL be a single transfer-through; no beat lost or duplicated.
REQ-022 No starvation: with all channels valid, each channel SHALL be granted at least once in every NCH transfers (MAX_BURST*NCH when RR_MUX_HOLD_EN).

Reset
REQ-023 On reset: out_valid=0, out_data=0, out_sel=0, last_grant=NCH-1 (so channel 0 has first priority), burst counter=0.
REQ-024 in_ready SHALL be all zeros during any cycle reset is high.
REQ-025 Reset asserted mid-transfer SHALL discard the held output beat; no in_ready pulse in that cycle.

Configuration
REQ-026 Macro RR_MUX_HOLD_EN: when defined, the granted channel SHALL keep the grant while its in_valid stays high, up to MAX_BURST consecutive transfers, then rotate per REQ-017; grant releases early when its in_valid drops.
REQ-027 Without RR_MUX_HOLD_EN, grant SHALL rotate after every transfer and no burst counter SHALL be synthesised.

Structure
REQ-028 Package rr_mux_pkg SHALL hold the sel-width function/constant and the default WIDTH/NCH/MAX_BURST values.
REQ-029 Grant logic SHALL be a sub-module rr_arbiter (inputs req, last_grant; outputs one-hot grant, grant index); rr_mux instantiates it once.

Verification (WIDTH=4, NCH=4, out_ready=1 unless stated)
REQ-030 Reset then idle -> out_valid=0, in_ready=0000, out_data=0000, out_sel=0.
REQ-031 Only ch2 valid with data 1010 for 3 cycles -> in_ready=0100 each cycle; out_data=1010, out_sel=2 from cycle+1, 3 beats.
REQ-032 All valid, data ch0..3 = 0001,0010,0100,1000, no HOLD -> out_sel sequence 0,1,2,3,0 with matching data.
REQ-033 Ch1 and ch3 valid, out_ready=0 for 2 cycles -> in_ready=0000 while stalled, out_data held; on release order continues 3 after 1.
REQ-034 Reset asserted while out_valid=1, out_ready=0 -> next cycle out_valid=0, next grant goes to ch0 if valid.
REQ-035 With RR_MUX_HOLD_EN, MAX_BURST=2, all valid -> out_sel 0,0,1,1,2,2,3,3; drop ch0 valid after one beat -> next beat from ch1.
